// File: rtl/norm_wb.sv
// Purpose : write-back stage after normalization; requantizes each captured row
//           (rounding right-shift + saturation) and streams it to the output SRAM.
// Latency : row captured at edge E drives mem_wen in the cycle after E (no bypass).
// Backpressure: rows queue in a depth-entry FIFO while mem_ready is low; a row that
//           arrives while the FIFO is full and nothing pops is dropped (overflow).
//
// Ports:
//   clk, reset (async, active-low), start (restart pulse: base_addr/num_rows loaded)
//   shift      : rounding right-shift applied to every lane
//   norm_in    : col lanes of bw_psum signed bits, norm_wr: per-column strobe
//   mem_wen/mem_addr/mem_din/mem_ready : SRAM write port (held while stalled)
//   full, overflow, strobe_err, done   : status (overflow/strobe_err sticky)

// Generic FIFO: combinational head read, registered occupancy.
// Caller only pushes when not full (or popping) and only pops when non-empty.
module fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [width-1:0] wr_dat,
  input  logic             rd_en,
  output logic [width-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw:0]      cnt;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + aw'(1);
      if (rd_en) rd_ptr <= rd_ptr + aw'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (aw+1)'(1);
        2'b01:   cnt <= cnt - (aw+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign empty  = (cnt == '0);
  assign full   = (cnt == full_cnt);
endmodule

module norm_wb #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int addr_w  = 4,
  parameter int depth   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [addr_w:0]        num_rows,
  input  logic [4:0]             shift,
  input  logic [bw_psum*col-1:0] norm_in,
  input  logic [col-1:0]         norm_wr,
  input  logic                   mem_ready,
  output logic                   mem_wen,
  output logic [addr_w-1:0]      mem_addr,
  output logic [bw*col-1:0]      mem_din,
  output logic                   full,
  output logic                   overflow,
  output logic                   strobe_err,
  output logic                   done
);
  // One guard bit above the lane width so the rounding add cannot wrap.
  localparam int gw = bw_psum + 1;
  localparam logic signed [gw-1:0] qmax = gw'((2**(bw-1)) - 1);
  localparam logic signed [gw-1:0] qmin = gw'(-(2**(bw-1)));

  function automatic logic [bw-1:0] quant(input logic [bw_psum-1:0] x,
                                          input logic [4:0]         s);
    logic signed [gw-1:0] xe;
    logic signed [gw-1:0] r;
    xe = {x[bw_psum-1], x};
    if (s != 5'd0) xe = xe + (gw'(1) << (s - 5'd1));
    r = xe >>> s;
    if (r > qmax)      return qmax[bw-1:0];
    else if (r < qmin) return qmin[bw-1:0];
    else               return r[bw-1:0];
  endfunction

  logic [bw*col-1:0] q_row;
  logic [bw*col-1:0] head;
  logic              empty;
  logic              row_ok;
  logic              row_bad;
  logic              push;
  logic              pop;
  logic              drop;
  logic [addr_w:0]   acc_cnt;
  logic [addr_w:0]   next_cnt;
  logic [addr_w:0]   num_rows_q;

  always_comb begin
    q_row = '0;
    for (int i = 0; i < col; i++)
      q_row[bw*i +: bw] = quant(norm_in[bw_psum*i +: bw_psum], shift);
  end

  assign row_ok  = &norm_wr;
  assign row_bad = (|norm_wr) & ~row_ok;

  // start wins: no write is offered in the restart cycle, so the SRAM never
  // takes a row the restart is about to discard.
  assign mem_wen = ~empty & ~start;
  assign pop     = mem_wen & mem_ready;
  // A pop in the same cycle frees the slot, so full alone does not drop.
  assign push    = ~start & row_ok & (~full | pop);
  assign drop    = ~start & row_ok & full & ~pop;
  assign mem_din = mem_wen ? head : '0;
  assign next_cnt = acc_cnt + (addr_w+1)'(1);

  fifo #(.width(bw*col), .depth(depth)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clr    (start),
    .wr_en  (push),
    .wr_dat (q_row),
    .rd_en  (pop),
    .rd_dat (head),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr   <= '0;
      acc_cnt    <= '0;
      num_rows_q <= '0;
      overflow   <= 1'b0;
      strobe_err <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      mem_addr   <= base_addr;
      acc_cnt    <= '0;
      num_rows_q <= num_rows;
      overflow   <= 1'b0;
      strobe_err <= 1'b0;
      done       <= (num_rows == '0);
    end else begin
      if (pop) begin
        mem_addr <= mem_addr + addr_w'(1);
        acc_cnt  <= next_cnt;
        if (next_cnt == num_rows_q) done <= 1'b1;
      end
      if (drop)    overflow   <= 1'b1;
      if (row_bad) strobe_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_norm_wb.sv
module tb_norm_wb;
  localparam int COL = 8, BW = 8, BWP = 20, AW = 4, DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset, start, mem_ready;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      num_rows;
  logic [4:0]       shift;
  logic [BWP*COL-1:0] norm_in;
  logic [COL-1:0]   norm_wr;
  logic             mem_wen, full, overflow, strobe_err, done;
  logic [AW-1:0]    mem_addr;
  logic [BW*COL-1:0] mem_din;

  always #5 clk = ~clk;

  norm_wb #(.col(COL), .bw(BW), .bw_psum(BWP), .addr_w(AW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .shift(shift), .norm_in(norm_in), .norm_wr(norm_wr),
    .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .full(full), .overflow(overflow),
    .strobe_err(strobe_err), .done(done)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] q[$];
  int m_addr = 0, m_cnt = 0, m_nrows = 0;
  bit m_ovf = 0, m_serr = 0, m_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-half-up arithmetic shift, then clamp to signed 8 bits.
  function automatic logic [7:0] q8(input logic [19:0] x, input int s);
    longint v;
    v = longint'(signed'(x));
    if (s > 0) v = (v + (longint'(1) << (s - 1))) >>> s;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [63:0] row_exp(input logic [159:0] x, input int s);
    logic [63:0] r;
    logic [19:0] l;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      l = x[20*i +: 20];
      r[8*i +: 8] = q8(l, s);
    end
    return r;
  endfunction

  function automatic void model_edge();
    bit pop, was_full;
    logic [63:0] r;
    if (start) begin
      q.delete();
      m_addr = base_addr; m_cnt = 0; m_nrows = num_rows;
      m_ovf = 0; m_serr = 0; m_done = (num_rows == 0);
      return;
    end
    pop = (q.size() > 0) && mem_ready;
    was_full = (q.size() == DEPTH);
    if (norm_wr != 8'h00 && norm_wr != 8'hFF) m_serr = 1;
    r = row_exp(norm_in, shift);
    if (pop) begin
      void'(q.pop_front());
      m_addr = (m_addr + 1) % 16;
      m_cnt = (m_cnt + 1) % 32;
      if (m_cnt == m_nrows) m_done = 1;
    end
    if (norm_wr == 8'hFF) begin
      if (was_full && !pop) m_ovf = 1;
      else q.push_back(r);
    end
  endfunction

  task automatic check_all();
    bit exp_wen;
    exp_wen = (q.size() > 0) && !start;
    chk("mem_wen", mem_wen, exp_wen);
    chk("mem_addr", mem_addr, m_addr);
    if (exp_wen) chk("mem_din", mem_din, q[0]);
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("strobe_err", strobe_err, m_serr);
    chk("done", done, m_done);
  endtask

  // Inputs are set at the falling edge, the model follows the rising edge,
  // and outputs are checked at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_lanes();
    logic [31:0] t;
    for (int i = 0; i < 8; i++) begin
      t = $urandom;
      norm_in[20*i +: 20] = t[31] ? {{12{t[7]}}, t[7:0]} : t[19:0];
    end
  endtask

  task automatic do_start(input int b, input int n, input int s);
    start = 1; base_addr = AW'(b); num_rows = 5'(n); shift = 5'(s); norm_wr = 0;
    cyc();
    start = 0;
  endtask

  task automatic send_row(input bit rdy);
    rand_lanes(); norm_wr = 8'hFF; mem_ready = rdy;
    cyc();
    norm_wr = 0;
  endtask

  initial begin
    int writes;
    int addrs[$];
    int r;
    reset = 0; start = 0; base_addr = 0; num_rows = 0; shift = 0;
    norm_in = 0; norm_wr = 0; mem_ready = 0;
    #1;
    chk("rst_wen", mem_wen, 0);  chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);  chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0); chk("rst_serr", strobe_err, 0);
    chk("rst_done", done, 0);
    repeat (2) cyc();
    reset = 1;
    cyc();

    // Single row, shift 4
    do_start(5, 1, 4);
    norm_wr = 8'hFF; mem_ready = 1;
    norm_in[0*20 +: 20] = 20'h00100; norm_in[1*20 +: 20] = 20'hFFF00;
    norm_in[2*20 +: 20] = 20'h00018; norm_in[3*20 +: 20] = 20'hFFFE8;
    norm_in[4*20 +: 20] = 20'h00000; norm_in[5*20 +: 20] = 20'h00007;
    norm_in[6*20 +: 20] = 20'h00008; norm_in[7*20 +: 20] = 20'hFFFF8;
    cyc();
    norm_wr = 0;
    chk("single_wen", mem_wen, 1);
    chk("single_addr", mem_addr, 5);
    chk("single_din", mem_din, 64'h00010000FF02F010);
    cyc();
    chk("single_done", done, 1);
    chk("single_addr_inc", mem_addr, 6);

    // Saturation
    do_start(0, 1, 0);
    rand_lanes(); norm_in[19:0] = 20'h7FFFF; norm_in[39:20] = 20'h80000; norm_wr = 8'hFF;
    cyc();
    norm_wr = 0;
    chk("sat_pos", mem_din[7:0], 8'h7F);
    chk("sat_neg", mem_din[15:8], 8'h80);
    cyc();
    do_start(0, 1, 19);
    rand_lanes(); norm_in[19:0] = 20'h40000; norm_wr = 8'hFF;
    cyc();
    norm_wr = 0;
    chk("shift19", mem_din[7:0], 8'h01);
    cyc();

    // Backpressure: 5 rows into a 4-deep FIFO
    do_start(0, 4, $urandom_range(0, 19));
    for (int k = 0; k < 5; k++) begin
      send_row(0);
      if (k == 3) begin chk("bp_full", full, 1); chk("bp_ovf_pre", overflow, 0); end
      if (k == 4) chk("bp_ovf", overflow, 1);
    end
    mem_ready = 1; writes = 0;
    for (int k = 0; k < 8; k++) begin
      if (mem_wen && mem_ready) writes++;
      cyc();
    end
    chk("bp_writes", writes, 4);
    chk("bp_done", done, 1);

    // Full FIFO with simultaneous push and pop
    do_start(7, 8, $urandom_range(0, 19));
    for (int k = 0; k < 4; k++) send_row(0);
    chk("fp_full_pre", full, 1);
    send_row(1);
    chk("fp_ovf", overflow, 0);
    chk("fp_full", full, 1);
    repeat (6) cyc();

    // Address wrap
    do_start(14, 4, $urandom_range(0, 19));
    addrs.delete();
    for (int k = 0; k < 10; k++) begin
      if (mem_wen && mem_ready) addrs.push_back(int'(mem_addr));
      if (k < 4) send_row(1); else cyc();
    end
    chk("wrap_count", addrs.size(), 4);
    if (addrs.size() == 4) begin
      chk("wrap_a0", addrs[0], 14); chk("wrap_a1", addrs[1], 15);
      chk("wrap_a2", addrs[2], 0);  chk("wrap_a3", addrs[3], 1);
    end

    // Strobe error and restart
    mem_ready = 1; norm_wr = 8'h0F;
    cyc();
    norm_wr = 0;
    chk("serr_set", strobe_err, 1);
    chk("serr_nopush", mem_wen, 0);
    do_start(3, 2, $urandom_range(0, 19));
    chk("restart_serr", strobe_err, 0);
    send_row(1);
    chk("restart_wen", mem_wen, 1);
    chk("restart_addr", mem_addr, 3);
    cyc();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_start($urandom_range(0, 15), $urandom_range(0, 20), $urandom_range(0, 19));
      end else begin
        rand_lanes();
        r = $urandom_range(0, 9);
        norm_wr = (r < 5) ? 8'hFF : (r < 9) ? 8'h00 : 8'($urandom_range(1, 254));
        mem_ready = ($urandom_range(0, 9) < 7);
        cyc();
        norm_wr = 0;
      end
    end

    // Reset in the middle of a burst
    do_start(9, 10, 2);
    for (int k = 0; k < 5; k++) send_row(0);
    norm_wr = 8'h01;
    cyc();
    norm_wr = 0;
    reset = 0;
    #1;
    chk("mrst_wen", mem_wen, 0);  chk("mrst_addr", mem_addr, 0);
    chk("mrst_din", mem_din, 0);  chk("mrst_full", full, 0);
    chk("mrst_ovf", overflow, 0); chk("mrst_serr", strobe_err, 0);
    chk("mrst_done", done, 0);
    q.delete(); m_addr = 0; m_cnt = 0; m_nrows = 0; m_ovf = 0; m_serr = 0; m_done = 0;
    cyc();
    reset = 1;
    do_start(2, 1, 0);
    send_row(1);
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
